// File: rtl/power_pkg.sv
// power_pkg: fixed-point widths, FSM encoding and the unit constant shared with the division/root blocks.
package power_pkg;
    localparam int IN_W     = 10;
    localparam int EXP_W    = 3;
    localparam int OUT_FRAC = 20;
    localparam int OUT_W    = OUT_FRAC + 1;
    localparam int PART_W   = OUT_W + IN_W;
    localparam int CNT_W    = $clog2(IN_W);
    localparam logic [OUT_W-1:0] ONE = OUT_W'(1) << OUT_FRAC;

    typedef enum logic [1:0] {IDLE, LOAD, MUL, DONE} state_t;
endpackage

// File: rtl/power_mul_step.sv
// power_mul_step: IN_W-cycle LSB-first shift-add multiply of acc by fraction x, truncated back to Q1.OUT_FRAC.
// Bit 0 is consumed in the start cycle and done is combinational in the last bit cycle, so each multiply costs exactly IN_W cycles.
module power_mul_step
    import power_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [OUT_W-1:0] acc,
    input  logic [IN_W-1:0]  x,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] prod
);
    logic              busy_q, busy_d;
    logic [CNT_W-1:0]  bitcnt_q, bitcnt_d;
    logic [PART_W-1:0] partial_q, partial_d;
    logic [PART_W-1:0] term, sum;
    logic              active;

    always_comb begin
        active    = busy_q | start;
        term      = x[bitcnt_q] ? (PART_W'(acc) << bitcnt_q) : '0;
        sum       = partial_q + term;
        done      = active && (bitcnt_q == CNT_W'(IN_W - 1));
        prod      = OUT_W'(sum >> IN_W);
        busy_d    = active && !done;
        bitcnt_d  = done ? '0 : (active ? bitcnt_q + 1'b1 : bitcnt_q);
        partial_d = done ? '0 : (active ? sum : partial_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q    <= 1'b0;
            bitcnt_q  <= '0;
            partial_q <= '0;
        end else begin
            busy_q    <= busy_d;
            bitcnt_q  <= bitcnt_d;
            partial_q <= partial_d;
        end
    end

    assign busy = busy_q;
endmodule

// File: rtl/power.sv
// power: x^n for an unsigned Q0.IN_W base and small integer exponent, result in Q1.OUT_FRAC.
// Sequences power_mul_step n times starting from 1.0; the strobe fires on entry to DONE.
module power
    import power_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_data_1,
    input  logic [EXP_W-1:0] in_data_2,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_data
);
    state_t           state_q, state_d;
    logic [IN_W-1:0]  x_q, x_d;
    logic [EXP_W-1:0] n_q, n_d;
    logic [EXP_W-1:0] rem_q, rem_d;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] out_data_q, out_data_d;
    logic             mul_start, mul_busy, mul_done;
    logic [OUT_W-1:0] mul_prod;

    assign mul_start = (state_q == MUL) && (rem_q != '0) && !mul_busy;

    power_mul_step u_mul (
        .clk   (clk),
        .rst_n (rst_n),
        .start (mul_start),
        .acc   (acc_q),
        .x     (x_q),
        .busy  (mul_busy),
        .done  (mul_done),
        .prod  (mul_prod)
    );

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        n_d         = n_q;
        rem_d       = rem_q;
        acc_d       = acc_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    x_d     = in_data_1;
                    n_d     = in_data_2;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    x_d = in_data_1;
                    n_d = in_data_2;
                end else begin
                    acc_d   = ONE;
                    rem_d   = n_q;
                    state_d = MUL;
                end
            end
            MUL: begin
                if (mul_done) begin
                    acc_d = mul_prod;
                    rem_d = rem_q - 1'b1;
                end else if (rem_q == '0 && !mul_busy) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    out_data_d  = acc_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            x_q         <= '0;
            n_q         <= '0;
            rem_q       <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            n_q         <= n_d;
            rem_q       <= rem_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
endmodule
